// File: rtl/apb_reg_slave_1.sv
// APB completer with a bank of 32-bit registers, configurable wait states and PSLVERR.
// Register 0 is a read-only ID; register contents are exported flattened on reg_q.
module apb_reg_slave_1 #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h0004_0000,
    parameter int unsigned            REG_NUM     = 8,
    parameter logic [DATA_WIDTH-1:0]  ID_VALUE    = 32'hA9B0_0001,
    parameter int unsigned            WAIT_STATES = 1,
    parameter logic [15:0]            SECURE_MASK = 16'h0002
) (
    input  logic                          pclk,
    input  logic                          prst,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic [2:0]                    pprot,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
);

    localparam int unsigned           STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W     = $clog2(REG_NUM);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(REG_NUM * 4);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   capture, commit;
    logic [IDX_W-1:0]       idx_q;
    logic                   write_q, err_q;
    logic [DATA_WIDTH-1:0]  wdata_q, prdata_q;
    logic [STRB_W-1:0]      strb_q;
    logic [DATA_WIDTH-1:0]  regs_q [REG_NUM];

    logic [ADDR_WIDTH-1:0]  off;
    logic [IDX_W-1:0]       idx;
    logic                   setup_err;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   unused;

    assign off    = paddr - BASE_ADDR;
    assign idx    = off[2 +: IDX_W];
    assign unused = ^{pprot[2], pprot[0], off[1:0]};

    // Below-base check is independent of the subtraction, so a wrapped offset never aliases.
    always_comb begin
        setup_err = (paddr < BASE_ADDR) || (off >= WIN_BYTES) || (paddr[1:0] != 2'b00) ||
                    (pwrite && (idx == '0)) || (SECURE_MASK[idx] && pprot[1]);
        rdata     = (idx == '0) ? ID_VALUE : regs_q[idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        pready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                pready = (cnt_q == 4'd0);
                if (!psel) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (pready && penable) begin
                    commit  = write_q && !err_q;
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pslverr = pready & err_q;
    assign prdata  = prdata_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else if (capture) begin
            idx_q    <= idx;
            write_q  <= pwrite;
            err_q    <= setup_err;
            wdata_q  <= pwdata;
            strb_q   <= pstrb;
            prdata_q <= (setup_err || pwrite) ? '0 : rdata;
        end else if (state_q == StAccess && state_d == StIdle) begin
            prdata_q <= '0;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (commit) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (strb_q[k]) regs_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_reg_slave_1.sv
// Directed bench for apb_reg_slave_1: three instances with 1, 0 and 3 wait states
// share the APB bus; each has its own select.
module tb_apb_reg_slave_1;

    logic         pclk = 1'b0;
    logic         prst = 1'b1;
    logic [2:0]   psel_v;
    logic         penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [31:0]  prdata_w  [3];
    logic         pready_w  [3];
    logic         pslverr_w [3];
    logic [255:0] regq_w    [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    apb_reg_slave_1 #(.WAIT_STATES(1)) u_ws1 (
        .pclk(pclk), .prst(prst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata_w[0]),
        .pready(pready_w[0]), .pslverr(pslverr_w[0]), .reg_q(regq_w[0])
    );
    apb_reg_slave_1 #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .prst(prst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata_w[1]),
        .pready(pready_w[1]), .pslverr(pslverr_w[1]), .reg_q(regq_w[1])
    );
    apb_reg_slave_1 #(.WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .prst(prst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata_w[2]),
        .pready(pready_w[2]), .pslverr(pslverr_w[2]), .reg_q(regq_w[2])
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Setup at a negedge, access from the next; returns at the negedge where pready is high.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic err, output int acc);
        @(negedge pclk);
        psel_v        = '0;
        psel_v[which] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(negedge pclk);
        penable = 1'b1;
        acc     = 1;
        while (!pready_w[which] && acc < 20) begin
            @(negedge pclk);
            acc++;
        end
        rd  = prdata_w[which];
        err = pslverr_w[which];
    endtask

    task automatic go_idle();
        @(negedge pclk);
        psel_v  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        pprot   = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic         err;
        int           acc;
        logic         seen;
        logic [255:0] img;

        psel_v = '0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
        repeat (3) @(negedge pclk);
        chk("rst_pready",  pready_w[0],  1'b0);
        chk("rst_pslverr", pslverr_w[0], 1'b0);
        chk("rst_prdata",  prdata_w[0],  32'h0);
        chk("rst_reg_q",   regq_w[0],    256'h0);
        prst = 1'b0;

        // ID read, one wait state
        xfer(0, 1'b0, 32'h0004_0000, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("id_latency", acc, 2);
        chk("id_data", rd, 32'hA9B0_0001);
        chk("id_err", err, 1'b0);
        go_idle();
        chk("idle_prdata", prdata_w[0], 32'h0);

        // Partial-strobe write over a full write
        xfer(0, 1'b1, 32'h0004_0008, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, err, acc);
        xfer(0, 1'b1, 32'h0004_0008, 32'h1234_5678, 4'b0101, 3'b000, rd, err, acc);
        chk("strb_err", err, 1'b0);
        go_idle();
        chk("strb_reg2", regq_w[0][2*32 +: 32], 32'hFF34_FF78);
        xfer(0, 1'b0, 32'h0004_0008, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("strb_readback", rd, 32'hFF34_FF78);
        go_idle();

        img = '0;
        img[2*32 +: 32] = 32'hFF34_FF78;

        // Error cases
        xfer(0, 1'b1, 32'h0004_0000, 32'h5555_5555, 4'hF, 3'b000, rd, err, acc);
        chk("err_wr_id", err, 1'b1);
        xfer(0, 1'b1, 32'h0004_0020, 32'h6666_6666, 4'hF, 3'b000, rd, err, acc);
        chk("err_wr_oor", err, 1'b1);
        xfer(0, 1'b0, 32'h0004_000A, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("err_rd_unal", err, 1'b1);
        chk("err_rd_unal_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h0003_FFFC, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("err_rd_below", err, 1'b1);
        chk("err_rd_below_data", rd, 32'h0);
        go_idle();
        chk("err_no_change", regq_w[0], img);

        // Secure register 1
        xfer(0, 1'b1, 32'h0004_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, rd, err, acc);
        chk("sec_nonsec_err", err, 1'b1);
        go_idle();
        chk("sec_nonsec_reg1", regq_w[0][1*32 +: 32], 32'h0);
        xfer(0, 1'b1, 32'h0004_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, acc);
        chk("sec_ok_err", err, 1'b0);
        go_idle();
        chk("sec_ok_reg1", regq_w[0][1*32 +: 32], 32'hDEAD_BEEF);

        // Zero strobe write is a legal no-op
        xfer(0, 1'b1, 32'h0004_000C, 32'hFFFF_FFFF, 4'h0, 3'b000, rd, err, acc);
        chk("strb0_err", err, 1'b0);
        go_idle();
        chk("strb0_reg3", regq_w[0][3*32 +: 32], 32'h0);

        // Back-to-back on the zero-wait instance
        xfer(1, 1'b1, 32'h0004_000C, 32'hCAFE_F00D, 4'hF, 3'b000, rd, err, acc);
        chk("b2b_wr_latency", acc, 1);
        xfer(1, 1'b0, 32'h0004_000C, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("b2b_rd_latency", acc, 1);
        chk("b2b_rd_data", rd, 32'hCAFE_F00D);
        go_idle();

        // Abort on the three-wait instance
        @(negedge pclk);
        psel_v = 3'b100; penable = 0; pwrite = 1; paddr = 32'h0004_0008;
        pwdata = 32'h1111_1111; pstrb = 4'hF; pprot = 3'b000;
        @(negedge pclk);
        penable = 1'b1;
        seen = pready_w[2];
        @(negedge pclk);
        seen |= pready_w[2];
        @(negedge pclk);
        seen |= pready_w[2];
        psel_v = '0; penable = 0;
        repeat (5) begin
            @(negedge pclk);
            seen |= pready_w[2];
        end
        chk("abort_no_pready", seen, 1'b0);
        chk("abort_reg2", regq_w[2][2*32 +: 32], 32'h0);
        xfer(2, 1'b0, 32'h0004_0008, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("abort_next_latency", acc, 4);
        chk("abort_next_data", rd, 32'h0);
        go_idle();

        // Reset during the completion cycle of a write
        xfer(0, 1'b1, 32'h0004_0010, 32'h55AA_55AA, 4'hF, 3'b000, rd, err, acc);
        chk("rstmid_pready_before", pready_w[0], 1'b1);
        prst = 1'b1;
        #1;
        chk("rstmid_pready", pready_w[0], 1'b0);
        chk("rstmid_pslverr", pslverr_w[0], 1'b0);
        chk("rstmid_prdata", prdata_w[0], 32'h0);
        go_idle();
        @(negedge pclk);
        prst = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rstmid_reg_q", regq_w[0], 256'h0);
        xfer(0, 1'b1, 32'h0004_0010, 32'h55AA_55AA, 4'hF, 3'b000, rd, err, acc);
        chk("post_rst_latency", acc, 2);
        chk("post_rst_err", err, 1'b0);
        go_idle();
        chk("post_rst_reg4", regq_w[0][4*32 +: 32], 32'h55AA_55AA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
